// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap sequencer.
//   - state_t     : sequencer FSM states
//   - N_DEFAULT   : default number of taps / coefficients per load
//   - WIDTH_DEFAULT : default signed sample width
//   - COEF_W      : coefficient bus width
//   - TAP_WE_ALL  : byte-enable pattern that appends one full coefficient
package fir_pkg;

  localparam int N_DEFAULT     = 11;
  localparam int WIDTH_DEFAULT = 32;
  localparam int COEF_W        = 32;

  localparam logic [3:0] TAP_WE_ALL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_RUN
  } state_t;

endpackage

// File: rtl/fir_valid_pipe.sv
// LAT-deep 1-bit shift register that delays the sample-accept strobe so it
// lines up with the external FIR's result.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, clears the whole pipe
//   i_valid : accepted-sample strobe
//   o_valid : i_valid delayed by exactly LAT cycles
module fir_valid_pipe #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  output logic o_valid
);

  logic [LAT-1:0] r_pipe;

  generate
    if (LAT == 1) begin : g_single
      always_ff @(posedge clk) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples its input from before the edge, independent of
        // statement order.
        if (rst) r_pipe <= '0;
        else     r_pipe <= i_valid;
      end
    end else begin : g_deep
      always_ff @(posedge clk) begin
        if (rst) r_pipe <= '0;
        else     r_pipe <= {r_pipe[LAT-2:0], i_valid};
      end
    end
  endgenerate

  assign o_valid = r_pipe[LAT-1];

endmodule

// File: rtl/fir_tap_seq.sv
// Sequencer around an external FIR: reloads the N coefficients, flushes the
// FIR delay line with zeros, then streams samples through it.
// Ports:
//   clk, rst                : clock and synchronous active-high reset
//   cfg_start               : pulse, request a coefficient reload (IDLE/RUN)
//   coef_valid/coef_data    : coefficient stream in, coef_ready handshake out
//   cfg_done                : one-cycle pulse on entry to RUN after a load
//   tap_ram_in/tap_ram_we   : FIR coefficient append port
//   in_valid/in_data        : sample stream in, in_ready handshake out
//   fir_x_in / fir_y_in     : sample to FIR / FIR result (LAT cycles later)
//   out_valid/out_data      : filtered result, no backpressure
//   busy                    : high while loading or flushing
module fir_tap_seq
  import fir_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              coef_valid,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_ready,
  output logic              cfg_done,
  output logic [COEF_W-1:0] tap_ram_in,
  output logic [3:0]        tap_ram_we,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic [WIDTH-1:0]  fir_x_in,
  input  logic [WIDTH-1:0]  fir_y_in,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic              busy
);

  // One counter width serves both the coefficient index and the flush length.
  localparam int CNT_W = $clog2(N + LAT + 1);
  localparam logic [CNT_W-1:0] COEF_LAST  = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(N + LAT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_coef_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             r_cfg_done;

  logic w_coef_hs;
  logic w_in_hs;
  logic w_coef_last;
  logic w_flush_last;
  logic w_out_valid;

  assign w_coef_hs    = (r_state == ST_LOAD) && coef_valid;
  assign w_in_hs      = (r_state == ST_RUN) && in_valid;
  assign w_coef_last  = w_coef_hs && (r_coef_cnt == COEF_LAST);
  assign w_flush_last = (r_state == ST_FLUSH) && (r_flush_cnt == FLUSH_LAST);

  // State, counters and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_coef_cnt  <= '0;
      r_flush_cnt <= '0;
      r_cfg_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      // cfg_done is registered so it lands in the first RUN cycle, after the
      // last flush cycle rather than overlapping it.
      r_cfg_done <= w_flush_last;

      // The coefficient index only lives inside LOAD; leaving LOAD for any
      // reason restarts the next load at index 0.
      if (r_state != ST_LOAD) begin
        r_coef_cnt <= '0;
      end else if (w_coef_hs) begin
        r_coef_cnt <= w_coef_last ? '0 : r_coef_cnt + CNT_W'(1);
      end

      if (r_state == ST_FLUSH) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      else                     r_flush_cnt <= '0;
    end
  end

  // Next-state and Moore/Mealy outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    coef_ready  = 1'b0;
    in_ready    = 1'b0;
    busy        = 1'b0;
    tap_ram_we  = '0;
    tap_ram_in  = '0;
    fir_x_in    = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (cfg_start) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        coef_ready = 1'b1;
        busy       = 1'b1;
        if (w_coef_hs) begin
          tap_ram_we = TAP_WE_ALL;
          tap_ram_in = coef_data;
        end
        // cfg_start is ignored here, even alongside the last handshake.
        if (w_coef_last) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        // fir_x_in stays at its zero default to clear the delay line.
        busy = 1'b1;
        if (w_flush_last) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        in_ready = 1'b1;
        if (w_in_hs) fir_x_in = in_data;
        if (cfg_start) w_state_nxt = ST_LOAD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The valid pipe keeps running regardless of state, so samples accepted
  // just before a reload still come out.
  fir_valid_pipe #(
    .LAT(LAT)
  ) u_valid_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_valid(w_in_hs),
    .o_valid(w_out_valid)
  );

  assign out_valid = w_out_valid;
  assign out_data  = w_out_valid ? fir_y_in : '0;
  assign cfg_done  = r_cfg_done;

endmodule

// File: tb/tb_fir_tap_seq.sv
// Self-checking bench for fir_tap_seq. A behavioural FIR sits on the
// coefficient/sample ports; expected results are computed from the bench's
// own coefficient and sample history and queued when the sample is driven.
module tb_fir_tap_seq;
  import fir_pkg::*;

  localparam int N   = 11;
  localparam int W   = 32;
  localparam int LAT = 1;

  logic          clk;
  logic          rst;
  logic          cfg_start;
  logic          coef_valid;
  logic [31:0]   coef_data;
  logic          coef_ready;
  logic          cfg_done;
  logic [31:0]   tap_ram_in;
  logic [3:0]    tap_ram_we;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic [W-1:0]  fir_x_in;
  logic [W-1:0]  fir_y_in;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          busy;

  fir_tap_seq #(.N(N), .WIDTH(W), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .coef_valid(coef_valid),
    .coef_data (coef_data),
    .coef_ready(coef_ready),
    .cfg_done  (cfg_done),
    .tap_ram_in(tap_ram_in),
    .tap_ram_we(tap_ram_we),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .fir_x_in  (fir_x_in),
    .fir_y_in  (fir_y_in),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural FIR (LAT-cycle latency) ----------------
  logic signed [W-1:0] m_coef  [N];
  logic signed [W-1:0] m_dl    [N];
  logic signed [W-1:0] m_ypipe [LAT];
  logic signed [W-1:0] m_ynext;
  int                  m_wptr;

  always_comb begin
    m_ynext = $signed(fir_x_in) * m_coef[0];
    for (int k = 1; k < N; k++) m_ynext = m_ynext + m_coef[k] * m_dl[k-1];
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        m_dl[k]   <= '0;
        m_coef[k] <= '0;
      end
      for (int i = 0; i < LAT; i++) m_ypipe[i] <= '0;
      m_wptr <= 0;
    end else begin
      m_dl[0] <= $signed(fir_x_in);
      for (int k = 1; k < N; k++) m_dl[k] <= m_dl[k-1];
      m_ypipe[0] <= m_ynext;
      for (int i = 1; i < LAT; i++) m_ypipe[i] <= m_ypipe[i-1];
      if (!busy) begin
        m_wptr <= 0;
      end else if (tap_ram_we == TAP_WE_ALL && m_wptr < N) begin
        m_coef[m_wptr] <= $signed(tap_ram_in);
        m_wptr         <= m_wptr + 1;
      end
    end
  end

  assign fir_y_in = m_ypipe[LAT-1];

  // ---------------- checking infrastructure ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int           due;
    logic         valid;
    logic [W-1:0] data;
  } sb_t;
  sb_t sb[$];

  int sw_coef [N];
  int sw_hist [N];

  bit mon_en = 1'b0;

  // Output monitor: every slot that has a queued expectation is compared;
  // any other out_valid is unexpected.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        sb_t e;
        e = sb.pop_front();
        check("out_valid", {63'd0, out_valid}, {63'd0, e.valid});
        check("out_data", {32'd0, out_data}, {32'd0, e.data});
      end else if (out_valid) begin
        check("unexpected out_valid", {63'd0, out_valid}, 64'd0);
      end
    end
  end

  typedef struct {
    logic        start;
    logic        cv;
    logic [31:0] cd;
    logic [3:0]  exp_we;
    logic [31:0] exp_ram;
  } lvec_t;

  lvec_t tbl_cont[$];
  lvec_t tbl_gap[$];

  int coefs1 [N] = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1};
  int coefs2 [N] = '{-3, 7, 0, 2, -1, 5, 4, -8, 9, 1, 6};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " coef_ready"}, {63'd0, coef_ready}, 64'd0);
    check({tag, " in_ready"},   {63'd0, in_ready},   64'd0);
    check({tag, " cfg_done"},   {63'd0, cfg_done},   64'd0);
    check({tag, " busy"},       {63'd0, busy},       64'd0);
    check({tag, " out_valid"},  {63'd0, out_valid},  64'd0);
    check({tag, " tap_ram_we"}, {60'd0, tap_ram_we}, 64'd0);
    check({tag, " tap_ram_in"}, {32'd0, tap_ram_in}, 64'd0);
    check({tag, " fir_x_in"},   {32'd0, fir_x_in},   64'd0);
    check({tag, " out_data"},   {32'd0, out_data},   64'd0);
  endtask

  // One RUN cycle: drive a sample (or bubble) and queue its expected result.
  task automatic run_cycle(input logic v, input int d, input logic start);
    int acc;
    in_valid  = v;
    in_data   = d;
    cfg_start = start;
    for (int k = N - 1; k > 0; k--) sw_hist[k] = sw_hist[k-1];
    sw_hist[0] = v ? d : 0;
    acc = 0;
    for (int k = 0; k < N; k++) acc += sw_coef[k] * sw_hist[k];
    sb.push_back('{due: cyc + LAT, valid: v, data: v ? W'(acc) : '0});
    @(negedge clk);
    check("in_ready in RUN", {63'd0, in_ready}, 64'd1);
    check("fir_x_in", {32'd0, fir_x_in}, v ? {32'd0, 32'(d)} : 64'd0);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    cfg_start = 1'b0;
  endtask

  // Full reload: optional cfg_start pulse, table-driven coefficient phase,
  // flush length measurement and cfg_done pulse. Ends in RUN.
  task automatic do_load(input bit send_start, input lvec_t tbl[$], input int c_new[N]);
    int flush_cyc = 0;
    int guard     = 0;
    bit x_ok      = 1'b1;
    bit we_ok     = 1'b1;
    if (send_start) begin
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
    end
    foreach (tbl[i]) begin
      cfg_start  = tbl[i].start;
      coef_valid = tbl[i].cv;
      coef_data  = tbl[i].cd;
      @(negedge clk);
      check("coef_ready in LOAD", {63'd0, coef_ready}, 64'd1);
      check("in_ready in LOAD",   {63'd0, in_ready},   64'd0);
      check("busy in LOAD",       {63'd0, busy},       64'd1);
      check("tap_ram_we",         {60'd0, tap_ram_we}, {60'd0, tbl[i].exp_we});
      if (tbl[i].exp_we != 4'h0)
        check("tap_ram_in", {32'd0, tap_ram_in}, {32'd0, tbl[i].exp_ram});
      tick();
    end
    // Keep offering junk coefficients: none may be written during FLUSH.
    cfg_start  = 1'b0;
    coef_valid = 1'b1;
    coef_data  = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      if (cfg_done) break;
      if (busy && !coef_ready) flush_cyc++;
      if (fir_x_in != '0)   x_ok  = 1'b0;
      if (tap_ram_we != '0) we_ok = 1'b0;
      guard++;
      if (guard > 100) begin
        check("cfg_done within bound", {63'd0, cfg_done}, 64'd1);
        break;
      end
      tick();
    end
    coef_valid = 1'b0;
    check("flush cycles",          64'(flush_cyc), 64'(N + LAT));
    check("flush fir_x_in zero",   {63'd0, x_ok},  64'd1);
    check("no write after Nth",    {63'd0, we_ok}, 64'd1);
    check("busy at cfg_done",      {63'd0, busy},  64'd0);
    check("in_ready at cfg_done",  {63'd0, in_ready}, 64'd1);
    tick();
    @(negedge clk);
    check("cfg_done one cycle", {63'd0, cfg_done}, 64'd0);
    tick();
    for (int k = 0; k < N; k++) begin
      sw_coef[k] = c_new[k];
      sw_hist[k] = 0;
    end
  endtask

  initial begin
    bit gap_ok;

    // Load tables: continuous stream (cfg_start pulses mid-load and on the
    // Nth handshake), and a stream with a gap every other cycle.
    for (int i = 0; i < N; i++)
      tbl_cont.push_back('{start: (i == 3 || i == N - 1), cv: 1'b1, cd: 32'(coefs1[i]),
                           exp_we: 4'hF, exp_ram: 32'(coefs1[i])});
    for (int j = 0; j < 2 * N; j++) begin
      logic v;
      v = (j % 2 == 1);
      tbl_gap.push_back('{start: (j == 7), cv: v, cd: v ? 32'(coefs2[j/2]) : 32'hDEAD_BEEF,
                          exp_we: v ? 4'hF : 4'h0, exp_ram: 32'(coefs2[j/2])});
    end
    for (int k = 0; k < N; k++) begin
      sw_coef[k] = 0;
      sw_hist[k] = 0;
    end

    // Reset with every input active: reset must win.
    rst        = 1'b1;
    cfg_start  = 1'b1;
    coef_valid = 1'b1;
    coef_data  = 32'h1234_5678;
    in_valid   = 1'b1;
    in_data    = 32'h0000_00AA;
    repeat (3) tick();
    @(negedge clk);
    reset_checks("reset");
    tick();
    rst        = 1'b0;
    cfg_start  = 1'b0;
    coef_valid = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    tick();
    mon_en = 1'b1;

    // Continuous load.
    do_load(1'b1, tbl_cont, coefs1);

    // Impulse response must replay the coefficients.
    run_cycle(1'b1, 1, 1'b0);
    repeat (N + 2) run_cycle(1'b1, 0, 1'b0);

    // Three-cycle bubble.
    run_cycle(1'b1, 5, 1'b0);
    run_cycle(1'b1, 7, 1'b0);
    repeat (3) run_cycle(1'b0, 32'h55, 1'b0);
    run_cycle(1'b1, 9, 1'b0);
    repeat (4) run_cycle(1'b1, 0, 1'b0);

    // Triangle, reload requested alongside the last sample.
    for (int t = 0; t <= 40; t++)
      run_cycle(1'b1, (t <= 20) ? t : 40 - t, (t == 40));

    // Second load with gaps; in_ready must already be low in its first cycle.
    do_load(1'b0, tbl_gap, coefs2);

    // Random samples through the new coefficient set.
    repeat (15) run_cycle(1'b1, int'($urandom_range(200)) - 100, 1'b0);
    repeat (N + 1) run_cycle(1'b1, 0, 1'b0);

    // Reset after the 5th coefficient of a new load.
    cfg_start = 1'b1;
    tick();
    cfg_start  = 1'b0;
    coef_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      coef_data = 32'(coefs1[i]);
      tick();
    end
    coef_data = 32'(coefs1[5]);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'd77;
    tick();
    @(negedge clk);
    reset_checks("mid-load reset");
    tick();
    rst    = 1'b0;
    gap_ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (tap_ram_we != '0 || coef_ready || busy || in_ready) gap_ok = 1'b0;
      tick();
    end
    check("idle until new cfg_start", {63'd0, gap_ok}, 64'd1);
    coef_valid = 1'b0;
    in_valid   = 1'b0;

    // A fresh load after reset runs to completion.
    do_load(1'b1, tbl_cont, coefs1);
    run_cycle(1'b1, 2, 1'b0);
    repeat (N + 1) run_cycle(1'b1, 0, 1'b0);

    repeat (LAT + 2) tick();
    check("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_tap_seq.md
FIR_TAP_SEQ -- requirements
Module: fir_tap_seq

Interface
Parameters:
REQ-001 N, 11, number of FIR taps and coefficients per load.
REQ-002 WIDTH, 32, sample width in bits (signed).
REQ-003 LAT, 1, FIR input-to-output latency in clk cycles (1..8).
Ports:
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cfg_start  in  1  pulse; requests a coefficient reload.
REQ-007 coef_valid / coef_data  in  1 / 32  coefficient stream, signed.
REQ-008 coef_ready  out  1  coefficient accepted when coef_valid&coef_ready.
REQ-009 cfg_done  out  1  one-cycle pulse when load and flush are complete.
REQ-010 tap_ram_in / tap_ram_we  out  32 / 4  FIR coefficient write port; each we=4'hF cycle appends one coefficient.
REQ-011 in_valid / in_data  in  1 / WIDTH  sample stream.
REQ-012 in_ready  out  1  sample accepted when in_valid&in_ready.
REQ-013 fir_x_in  out  WIDTH  sample driven to FIR; fir_y_in  in  WIDTH  FIR result.
REQ-014 out_valid / out_data  out  1 / WIDTH  filtered result; no backpressure.
REQ-015 busy  out  1  high in LOAD or FLUSH.

Function
REQ-016 FSM states IDLE, LOAD, FLUSH, RUN; encoding free.
REQ-017 IDLE: coef_ready=0, in_ready=0, fir_x_in=0; cfg_start -> LOAD.
REQ-018 LOAD: coef_ready=1; each handshake drives tap_ram_in=coef_data, tap_ram_we=4'hF in the same cycle, else we=0; the Nth handshake -> FLUSH.
REQ-019 coef_valid gaps stall LOAD without timeout; coef count is 0..N-1 with no wrap.
REQ-020 FLUSH: fir_x_in=0 for exactly N+LAT cycles to clear the delay line, then cfg_done pulses 1 cycle -> RUN.
REQ-021 RUN: in_ready=1; fir_x_in=in_data on handshake, else 0 (bubble).
REQ-022 Output valid pipeline: out_valid is the accepted-handshake bit delayed exactly LAT cycles; out_data=fir_y_in whenever out_valid=1, else 0.
REQ-023 cfg_start in RUN -> LOAD on the next cycle; in_ready drops in that cycle; samples in flight still emerge with out_valid.
REQ-024 cfg_start in LOAD or FLUSH is ignored.
REQ-025 cfg_start coincident with an Nth coefficient handshake: the handshake completes and the FSM goes to FLUSH.
REQ-026 The FSM never writes more than N coefficients per load.

Reset
REQ-027 rst wins over all inputs, including mid-LOAD and mid-FLUSH.
REQ-028 After rst: state IDLE; coef_ready=in_ready=cfg_done=busy=out_valid=0; tap_ram_we=0; tap_ram_in=fir_x_in=out_data=0; counters and the valid pipe are 0.
REQ-029 A partial load interrupted by rst is not completed; a fresh cfg_start is required.

Structure
REQ-030 Shared package fir_pkg holds the state enum, the N/WIDTH defaults and the TAP_WE_ALL=4'hF constant.
REQ-031 One sub-module, fir_valid_pipe (LAT-deep, 1-bit shift register with sync reset), implements REQ-022.
REQ-032 Target size is 120-400 RTL lines; no division or multiplication.

Verification
REQ-033 Load coefficients 1,2,3,4,5,6,5,4,3,2,1 continuously -> exactly 11 we=4'hF cycles in order, then 11+LAT flush cycles, then cfg_done for 1 cycle.
REQ-034 In RUN, impulse 1 followed by zeros -> out_valid samples 1,2,3,4,5,6,5,4,3,2,1 beginning LAT cycles after the impulse handshake.
REQ-035 Toggle coef_valid every other cycle during LOAD -> still exactly 11 writes; coef_ready is held high throughout LOAD.
REQ-036 Assert rst after the 5th coefficient -> all outputs reach reset values next cycle; no further writes until a new cfg_start.
REQ-037 Drive a triangle wave 0..20..0 in RUN, then cfg_start -> in_ready falls next cycle and the last LAT outputs still appear; the second load then completes normally.
REQ-038 Drop in_valid for 3 cycles in RUN -> those 3 output slots have out_valid=0 and out_data=0.
